// File: rtl/sm_hex_display_capture_pkg.sv
// Shared types and constants for the seven-segment capture monitor.
// Segment codes match the patterns driven by sm_hex_display_our (active-high, bit0 = a).
package sm_hex_capture_pkg;

    localparam int DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } cap_state_t;

    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

    // Blanking (all zero) and multi-hot selects are both rejected.
    function automatic logic sel_is_onehot(input logic [DIGITS-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sm_hex_display_capture_if.sv
// Segment bus input and decoded frame outputs of the capture monitor.
interface sm_hex_display_capture_if;
    logic [11:0] segBus;
    logic [11:0] value;
    logic        frameValid;
    logic        frameErr;
    logic        stale;

    modport master (output segBus, input value, frameValid, frameErr, stale);
    modport slave  (input segBus, output value, frameValid, frameErr, stale);
endinterface

// File: rtl/sm_hex_display_capture_decode.sv
// Combinational seven-segment to hex decoder; unknown patterns give nibble 0 and hex_ok = 0.
module sm_hex_segment_decode
    import sm_hex_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hex_ok
);

    always_comb begin
        nibble = 4'h0;
        hex_ok = 1'b1;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   hex_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/sm_hex_display_capture.sv
// Receive-side monitor for the multiplexed 3-digit seven-segment bus.
// Optional idle timeout (stale output) is built when SM_HEX_CAPTURE_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for a one-hot digit select
// SETTLE     | select latched, counting stable cycles
// CAPTURE    | decode segments into the selected slot (one cycle)
// HOLD       | digit taken, waiting for the select to change
module sm_hex_display_capture
    import sm_hex_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int SEG_ACTIVE_LOW = 1
`ifdef SM_HEX_CAPTURE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    sm_hex_display_capture_if.slave   bus
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [11:0] sync_q1, sync_q2, seg_word;
    logic [DIGITS-1:0] sel, cur_sel, seen;
    logic [7:0] settle_cnt;
    logic [3:0] dec_nibble;
    logic dec_ok, err_acc;
    logic latch_sel, settle_inc, do_capture;
    logic [DIGITS-1:0][3:0] slots, slots_next;
    logic unused_bits;
    cap_state_t state_q, state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.segBus;
            sync_q2 <= sync_q1;
        end
    end

    assign seg_word    = (SEG_ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;
    assign sel         = seg_word[10:8];
    assign unused_bits = ^{seg_word[11], seg_word[7]};

    sm_hex_segment_decode u_decode (
        .seg    (seg_word[6:0]),
        .nibble (dec_nibble),
        .hex_ok (dec_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:    if (sel_is_onehot(sel)) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (sel != cur_sel)                state_next = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: state_next = ST_HOLD;
            ST_HOLD:    if (sel != cur_sel) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_sel  = (state_q == ST_IDLE) && sel_is_onehot(sel);
        settle_inc = (state_q == ST_SETTLE) && (sel == cur_sel);
        do_capture = (state_q == ST_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sel    <= '0;
            settle_cnt <= '0;
        end else if (latch_sel) begin
            cur_sel    <= sel;
            settle_cnt <= '0;
        end else if (settle_inc) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    always_comb begin
        slots_next = slots;
        for (int i = 0; i < DIGITS; i++)
            if (cur_sel[i]) slots_next[i] = dec_ok ? dec_nibble : 4'h0;
    end

    // The completing capture publishes the merged slots directly, so value and the strobe land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots          <= '0;
            seen           <= '0;
            err_acc        <= 1'b0;
            bus.value      <= '0;
            bus.frameValid <= 1'b0;
            bus.frameErr   <= 1'b0;
        end else begin
            bus.frameValid <= 1'b0;
            if (do_capture) begin
                slots <= slots_next;
                if ((seen | cur_sel) == {DIGITS{1'b1}}) begin
                    bus.value      <= slots_next;
                    bus.frameValid <= 1'b1;
                    bus.frameErr   <= err_acc | ~dec_ok;
                    seen           <= '0;
                    err_acc        <= 1'b0;
                end else begin
                    seen    <= seen | cur_sel;
                    err_acc <= err_acc | ~dec_ok;
                end
            end
        end
    end

`ifdef SM_HEX_CAPTURE_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYCLES);
    logic [19:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst)                      idle_cnt <= '0;
        else if (do_capture)          idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_VAL) idle_cnt <= idle_cnt + 20'd1;
    end

    assign bus.stale = (idle_cnt == TIMEOUT_VAL);
`else
    assign bus.stale = 1'b0;
`endif

endmodule

// File: tb/tb_sm_hex_display_capture.sv
// Directed bench for sm_hex_display_capture with a frame scoreboard.
// Exercises the stale timeout when SM_HEX_CAPTURE_TIMEOUT_EN is defined.
module tb_sm_hex_display_capture;

    typedef struct packed {
        logic [11:0] value;
        logic        err;
    } frame_t;

    // Active-low segment patterns for the digits used below.
    localparam logic [6:0] AL_0   = 7'b1000000;
    localparam logic [6:0] AL_1   = 7'b1111001;
    localparam logic [6:0] AL_2   = 7'b0100100;
    localparam logic [6:0] AL_3   = 7'b0110000;
    localparam logic [6:0] AL_5   = 7'b0010010;
    localparam logic [6:0] AL_7   = 7'b1111000;
    localparam logic [6:0] AL_8   = 7'b0000000;
    localparam logic [6:0] AL_A   = 7'b0001000;
    localparam logic [6:0] AL_E   = 7'b0000110;
    localparam logic [6:0] AL_F   = 7'b0001110;
    localparam logic [6:0] AL_BAD = 7'b1110110;
    localparam logic [6:0] AL_OFF = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    frame_t sb[$];
    frame_t mon_exp;

    always #5 clk = ~clk;

    sm_hex_display_capture_if bus ();

`ifdef SM_HEX_CAPTURE_TIMEOUT_EN
    sm_hex_display_capture #(.SETTLE_CYCLES(16), .SEG_ACTIVE_LOW(1), .TIMEOUT_CYCLES(50))
        dut (.clk(clk), .rst(rst), .bus(bus));
`else
    sm_hex_display_capture #(.SETTLE_CYCLES(16), .SEG_ACTIVE_LOW(1))
        dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] sel, input logic [6:0] seg_al);
        bus.segBus = {1'b1, ~sel, 1'b1, seg_al};
    endtask

    task automatic digit(input int idx, input logic [6:0] seg_al);
        drive(3'(1 << idx), seg_al);
        step(40);
        drive(3'b000, AL_OFF);
        step(4);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.frameValid === 1'b1) begin
            strobe_cnt++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_strobe observed value=%0h expected no strobe", bus.value);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check("frame_value", 32'(bus.value), 32'(mon_exp.value));
                check("frame_err", 32'(bus.frameErr), 32'(mon_exp.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int waited;
        logic prev_stale;

        drive(3'b000, AL_OFF);
        step(3);
        check("reset_value", 32'(bus.value), 32'h0);
        check("reset_fv", 32'(bus.frameValid), 32'h0);
        check("reset_ferr", 32'(bus.frameErr), 32'h0);
        check("reset_stale", 32'(bus.stale), 32'h0);
        rst = 1'b0;
        step(2);

        // Ordered sweep 0,1,2 -> 123
        sb.push_back('{12'h123, 1'b0});
        digit(0, AL_3);
        digit(1, AL_2);
        digit(2, AL_1);
        step(5);
        check("sweep_value", 32'(bus.value), 32'h123);
        check("sweep_drained", 32'(sb.size()), 32'd0);
        check("sweep_strobes", 32'(strobe_cnt), 32'd1);
        check("strobe_one_cycle", 32'(bus.frameValid), 32'h0);

        // Glitch on digit0 must not capture; a later 1,2 pair must not complete a frame.
        drive(3'b001, AL_7);
        step(5);
        drive(3'b000, AL_OFF);
        step(40);
        check("glitch_value", 32'(bus.value), 32'h123);
        digit(1, AL_BAD);
        digit(2, AL_A);
        check("glitch_no_strobe", 32'(strobe_cnt), 32'd1);
        sb.push_back('{12'hA05, 1'b1});
        digit(0, AL_5);
        step(5);
        check("invalid_value", 32'(bus.value), 32'hA05);
        check("invalid_err", 32'(bus.frameErr), 32'h1);
        check("invalid_drained", 32'(sb.size()), 32'd0);

        // Mid-frame reset after two captures
        digit(0, AL_E);
        digit(2, AL_F);
        n = strobe_cnt;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_err", 32'(bus.frameErr), 32'h0);
        check("rst_fv", 32'(bus.frameValid), 32'h0);
        digit(0, AL_3);
        digit(0, AL_E);
        digit(1, AL_0);
        check("rst_partial_discarded", 32'(strobe_cnt), 32'(n));
        sb.push_back('{12'hF0E, 1'b0});
        digit(2, AL_F);
        step(5);
        check("after_rst_value", 32'(bus.value), 32'hF0E);
        check("after_rst_err", 32'(bus.frameErr), 32'h0);
        check("after_rst_strobes", 32'(strobe_cnt), 32'(n + 1));

        // Multi-hot select never captures
        n = strobe_cnt;
        drive(3'b011, AL_8);
        step(100);
        drive(3'b000, AL_OFF);
        step(10);
        check("multihot_no_strobe", 32'(strobe_cnt), 32'(n));
        check("multihot_value", 32'(bus.value), 32'hF0E);
`ifdef SM_HEX_CAPTURE_TIMEOUT_EN
        check("stale_idle", 32'(bus.stale), 32'h1);
`else
        check("stale_tied", 32'(bus.stale), 32'h0);
`endif

        // Frame 321 with a long gap before the last digit, then idle timeout
        sb.push_back('{12'h321, 1'b0});
        digit(0, AL_1);
        digit(1, AL_2);
        step(60);
        drive(3'b100, AL_3);
        waited = 0;
        prev_stale = bus.stale;
        while (bus.frameValid !== 1'b1 && waited < 100) begin
            prev_stale = bus.stale;
            step(1);
            waited++;
        end
        check("final_strobe_seen", 32'(bus.frameValid), 32'h1);
        drive(3'b000, AL_OFF);
`ifdef SM_HEX_CAPTURE_TIMEOUT_EN
        check("stale_at_capture", 32'(prev_stale), 32'h1);
        check("stale_cleared", 32'(bus.stale), 32'h0);
        step(49);
        check("stale_before_limit", 32'(bus.stale), 32'h0);
        step(1);
        check("stale_at_limit", 32'(bus.stale), 32'h1);
        step(20);
        check("stale_held", 32'(bus.stale), 32'h1);
`else
        check("stale_tied_end", 32'(bus.stale), 32'h0);
        step(70);
        check("stale_tied_idle", 32'(bus.stale), 32'h0);
`endif
        check("final_value", 32'(bus.value), 32'h321);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
